// File: rtl/pin_access_pkg.sv
// Shared types and width helpers for the PIN access controller.
package pin_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_GRANT,
    ST_DENY,
    ST_LOCKOUT
  } state_t;

  function automatic int unsigned pin_width(input int unsigned digit_w,
                                            input int unsigned num_digits);
    return digit_w * num_digits;
  endfunction

  // Width able to hold values 0..max_count inclusive, never below 1 bit.
  function automatic int unsigned count_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/pin_shift_reg.sv
// MSB-first digit collector: shifts digits in from the LSB end and counts them.
module pin_shift_reg
  import pin_access_pkg::*;
#(
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned NUM_DIGITS = 4,
  localparam int unsigned PIN_W     = pin_width(DIGIT_W, NUM_DIGITS),
  localparam int unsigned CNT_W     = count_width(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] digit,
  output logic [PIN_W-1:0]   data,
  output logic               last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en) begin
      data  <= (data << DIGIT_W) | PIN_W'(digit);
      count <= count + CNT_W'(1);
    end
  end

  // High while the next accepted digit completes the PIN.
  assign last = (count == CNT_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/pin_access_ctrl.sv
// PIN access controller: digit entry, compare with stored PIN, retry limit,
// timed lockout and in-session PIN change.
module pin_access_ctrl
  import pin_access_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] PIN_RESET = '1,
  localparam int unsigned PIN_W  = pin_width(DIGIT_W, NUM_DIGITS),
  localparam int unsigned FAIL_W = count_width(MAX_TRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               has_access,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               entry_clear,
  input  logic               pin_wr,
  input  logic [PIN_W-1:0]   pin_wr_data,
  output logic [3:0]         message,
  output logic               welcome,
  output logic               deny,
  output logic               locked,
  output logic [FAIL_W-1:0]  fail_count
);

  localparam int unsigned LOCK_W = count_width(LOCK_CYCLES);

  state_t             state;
  state_t             next_state;
  logic [PIN_W-1:0]   stored_pin;
  logic [PIN_W-1:0]   entered_pin;
  logic [LOCK_W-1:0]  lock_timer;
  logic [FAIL_W-1:0]  fail_next;
  logic               accept;
  logic               last_digit;
  logic               shift_clear;
  logic               pin_match;
  logic               lock_done;

  // clear beats a same-cycle digit, so a cleared digit is never shifted in
  assign accept      = (state == ST_ENTRY) && digit_valid && !entry_clear;
  // entered digits survive only through ENTRY and the single CHECK cycle
  assign shift_clear = ((state != ST_ENTRY) && (state != ST_CHECK)) ||
                       ((state == ST_ENTRY) && entry_clear);
  assign pin_match   = (entered_pin == stored_pin);
  assign fail_next   = fail_count + FAIL_W'(1);
  assign lock_done   = (lock_timer == LOCK_W'(LOCK_CYCLES - 1));

  pin_shift_reg #(
    .DIGIT_W    (DIGIT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (shift_clear),
    .shift_en (accept),
    .digit    (digit_in),
    .data     (entered_pin),
    .last     (last_digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (has_access) next_state = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (!has_access)                         next_state = ST_IDLE;
        else if (entry_clear)                    next_state = ST_ENTRY;
        else if (accept && last_digit)           next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (!has_access)                         next_state = ST_IDLE;
        else if (pin_match)                      next_state = ST_GRANT;
        else if (fail_next == FAIL_W'(MAX_TRIES)) next_state = ST_LOCKOUT;
        else                                     next_state = ST_DENY;
      end
      ST_GRANT: begin
        if (!has_access) next_state = ST_IDLE;
      end
      ST_DENY: begin
        next_state = has_access ? ST_ENTRY : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (lock_done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored_pin  <= PIN_RESET;
      fail_count  <= '0;
      lock_timer  <= '0;
      message     <= '0;
      welcome     <= 1'b0;
      deny        <= 1'b0;
      locked      <= 1'b0;
      digit_ready <= 1'b0;
    end else begin
      if ((state == ST_GRANT) && pin_wr) stored_pin <= pin_wr_data;

      if ((state == ST_CHECK) && has_access)
        fail_count <= pin_match ? '0 : fail_next;
      else if ((state == ST_LOCKOUT) && lock_done)
        fail_count <= '0;

      if (state == ST_LOCKOUT) lock_timer <= lock_timer + LOCK_W'(1);
      else                     lock_timer <= '0;

      message     <= ((next_state == ST_ENTRY) || (next_state == ST_CHECK) ||
                      (next_state == ST_GRANT) || (next_state == ST_DENY)) ? '1 : '0;
      welcome     <= (next_state == ST_GRANT);
      deny        <= (next_state == ST_DENY);
      locked      <= (next_state == ST_LOCKOUT);
      digit_ready <= (next_state == ST_ENTRY);
    end
  end

endmodule

// File: tb/tb_pin_access_ctrl.sv
// Directed self-checking bench for pin_access_ctrl with default parameters.
module tb_pin_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        has_access;
  logic        digit_valid;
  logic        digit_ready;
  logic [3:0]  digit_in;
  logic        entry_clear;
  logic        pin_wr;
  logic [15:0] pin_wr_data;
  logic [3:0]  message;
  logic        welcome;
  logic        deny;
  logic        locked;
  logic [1:0]  fail_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pin_access_ctrl #(
    .DIGIT_W     (4),
    .NUM_DIGITS  (4),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (16),
    .PIN_RESET   (16'hFFFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .has_access  (has_access),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_in    (digit_in),
    .entry_clear (entry_clear),
    .pin_wr      (pin_wr),
    .pin_wr_data (pin_wr_data),
    .message     (message),
    .welcome     (welcome),
    .deny        (deny),
    .locked      (locked),
    .fail_count  (fail_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents four digits on consecutive cycles; returns in the CHECK cycle.
  task automatic enter_pin(input logic [15:0] pin);
    for (int i = 0; i < 4; i++) begin
      digit_valid = 1'b1;
      digit_in    = pin[15-4*i -: 4];
      step();
    end
    digit_valid = 1'b0;
  endtask

  task automatic cycle_access();
    has_access = 1'b0;
    step();
    has_access = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; has_access = 1'b0; digit_valid = 1'b0; digit_in = '0;
    entry_clear = 1'b0; pin_wr = 1'b0; pin_wr_data = '0;
    step(); step();
    chk("rst_message", message, 0);
    chk("rst_welcome", welcome, 0);
    chk("rst_deny", deny, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_ready", digit_ready, 0);
    rst_n = 1'b1;

    has_access = 1'b1;
    step();
    chk("entry_message", message, 4'hF);
    chk("entry_ready", digit_ready, 1);
    enter_pin(16'hFFFF);
    chk("check_no_welcome", welcome, 0);
    chk("check_not_ready", digit_ready, 0);
    step();
    chk("grant_welcome", welcome, 1);
    chk("grant_fail", fail_count, 0);
    chk("grant_message", message, 4'hF);

    has_access = 1'b0;
    step();
    chk("drop_welcome", welcome, 0);
    chk("drop_message", message, 0);
    has_access = 1'b1;
    step();

    for (int t = 1; t <= 2; t++) begin
      enter_pin(16'h1234);
      step();
      chk("wrong_deny", deny, 1);
      chk("wrong_fail", fail_count, 32'(t));
      step();
      chk("deny_pulse_end", deny, 0);
      chk("reentry_ready", digit_ready, 1);
    end
    enter_pin(16'h1234);
    step();
    chk("lock_locked", locked, 1);
    chk("lock_fail", fail_count, 3);
    chk("lock_ready", digit_ready, 0);
    chk("lock_no_deny", deny, 0);
    for (int i = 1; i <= 15; i++) begin
      entry_clear = (i == 5);
      has_access  = (i != 8);
      step();
      chk("lock_hold", locked, 1);
      chk("lock_hold_ready", digit_ready, 0);
    end
    entry_clear = 1'b0;
    has_access  = 1'b1;
    step();
    chk("lock_expired", locked, 0);
    chk("lock_fail_cleared", fail_count, 0);
    chk("lock_idle_ready", digit_ready, 0);
    step();
    chk("post_lock_entry", digit_ready, 1);

    enter_pin(16'hFFFF);
    step();
    chk("grant2_welcome", welcome, 1);
    pin_wr = 1'b1; pin_wr_data = 16'h1234;
    step();
    pin_wr = 1'b0;
    chk("grant2_hold", welcome, 1);
    cycle_access();
    enter_pin(16'h1234);
    step();
    chk("newpin_welcome", welcome, 1);
    cycle_access();
    enter_pin(16'hFFFF);
    step();
    chk("oldpin_deny", deny, 1);
    chk("oldpin_fail", fail_count, 1);
    step();

    digit_valid = 1'b1; digit_in = 4'h1; step();
    digit_in = 4'h2; step();
    digit_in = 4'h3; entry_clear = 1'b1; pin_wr = 1'b1; pin_wr_data = 16'h0000;
    step();
    digit_valid = 1'b0; entry_clear = 1'b0; pin_wr = 1'b0;
    chk("clear_ready", digit_ready, 1);
    chk("clear_fail", fail_count, 1);
    chk("clear_no_deny", deny, 0);
    enter_pin(16'h1234);
    step();
    chk("clear_grant", welcome, 1);
    chk("clear_grant_fail", fail_count, 0);

    cycle_access();
    enter_pin(16'hFFFF);
    step();
    chk("pre_drop_deny", deny, 1);
    step();
    for (int i = 1; i <= 3; i++) begin
      digit_valid = 1'b1; digit_in = 4'(i); step();
    end
    digit_valid = 1'b0; has_access = 1'b0;
    step();
    chk("drop_entry_message", message, 0);
    chk("drop_entry_deny", deny, 0);
    step();
    chk("drop_entry_deny_late", deny, 0);
    has_access = 1'b1;
    step();
    chk("drop_entry_ready", digit_ready, 1);
    chk("drop_entry_fail", fail_count, 1);

    enter_pin(16'h1111);
    has_access = 1'b0;
    step();
    chk("drop_check_deny", deny, 0);
    chk("drop_check_locked", locked, 0);
    chk("drop_check_fail", fail_count, 1);
    chk("drop_check_message", message, 0);
    has_access = 1'b1;
    step();

    enter_pin(16'hFFFF);
    step();
    chk("relock_fail2", fail_count, 2);
    step();
    enter_pin(16'hFFFF);
    step();
    chk("relock_locked", locked, 1);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_fail", fail_count, 0);
    chk("async_rst_message", message, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_entry", digit_ready, 1);
    enter_pin(16'hFFFF);
    step();
    chk("post_rst_default_pin", welcome, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
